pattern_mem_test_ctrl: RTL and testbench

//  Sequencer for a RAM self-test in the storage test path. It writes a +STEP additive

---
 rtl/pattern_mem_test_ctrl_if.sv | 27 ++
 rtl/pattern_mem_test_ctrl.sv | 159 +++++++++++++++
 tb/tb_pattern_mem_test_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_mem_test_ctrl_if.sv
// Bus between the RAM self-test sequencer, the memory under test and host status logic.
interface pattern_mem_test_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [15:0]           err_count;
  logic [ADDR_WIDTH-1:0] err_addr;

  modport master (
    input  start, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy, done, pass, err_count, err_addr
  );

  modport slave (
    output start, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy, done, pass, err_count, err_addr
  );
endinterface

// File: rtl/pattern_mem_test_ctrl.sv
// RAM self-test sequencer: writes an additive pattern, reads it back, counts mismatches.
// Optional PMTC_STOP_ON_FAIL_EN: abort the sweep and finish on the first mismatch.
//
// state   | meaning
// S_IDLE  | waiting for start, results held
// S_WRITE | one pattern write per address
// S_READ  | one read issue per address, expected value queued in pipe
// S_DRAIN | no strobes, let the last compares land
// S_DONE  | one-cycle done pulse, results final
module pattern_mem_test_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int STEP       = 43
) (
  input logic                  clk,
  input logic                  aclr,
  pattern_mem_test_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [15:0]           err_count_q;
  logic [15:0]           err_count_d;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [CNT_W-1:0]      drain_q;
  logic                  miscmp;

  logic                  pipe_v_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_a_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_e_q [RD_LATENCY];

  always_comb begin
    miscmp      = pipe_v_q[RD_LATENCY-1] && (bus.mem_rdata != pipe_e_q[RD_LATENCY-1]);
    err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      acc_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      drain_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_a_q[i] <= '0;
        pipe_e_q[i] <= '0;
      end
    end else begin
      // acc_q is the pattern for the address currently on mem_addr, so it doubles as expected data
      pipe_v_q[0] <= mem_re_q;
      pipe_a_q[0] <= mem_addr_q;
      pipe_e_q[0] <= acc_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_e_q[i] <= pipe_e_q[i-1];
      end

      done_q <= 1'b0;

      if (miscmp) begin
        err_count_q <= err_count_d;
        if (err_count_q == 16'd0) err_addr_q <= pipe_a_q[RD_LATENCY-1];
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q     <= S_WRITE;
            busy_q      <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= '0;
            acc_q       <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            pass_q      <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
          acc_q      <= acc_q + DATA_WIDTH'(STEP);
          if (mem_addr_q == LAST_ADDR) begin
            state_q  <= S_READ;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b1;
            acc_q    <= '0;
          end
        end
        S_READ: begin
          mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
          acc_q      <= acc_q + DATA_WIDTH'(STEP);
          if (mem_addr_q == LAST_ADDR) begin
            state_q  <= S_DRAIN;
            mem_re_q <= 1'b0;
            acc_q    <= '0;
            drain_q  <= CNT_W'(RD_LATENCY);
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == 16'd0);
          end else begin
            drain_q <= drain_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef PMTC_STOP_ON_FAIL_EN
      if (miscmp && (state_q == S_READ || state_q == S_DRAIN)) begin
        state_q     <= S_DONE;
        mem_re_q    <= 1'b0;
        mem_addr_q  <= '0;
        acc_q       <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        pass_q      <= 1'b0;
        err_count_q <= 16'd1;
        for (int i = 0; i < RD_LATENCY; i++) pipe_v_q[i] <= 1'b0;
      end
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = acc_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_pattern_mem_test_ctrl.sv
// Bench for pattern_mem_test_ctrl: RAM model with injectable stuck bits, results predicted from the pattern rule.
module tb_pattern_mem_test_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int STEP  = 43;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic aclr = 1'b1;
  always #5 clk = ~clk;

  pattern_mem_test_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  pattern_mem_test_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(AW)) b8 ();

  pattern_mem_test_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .STEP(STEP))
    u_dut (.clk(clk), .aclr(aclr), .bus(bus));
  pattern_mem_test_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .STEP(STEP))
    u_dut8 (.clk(clk), .aclr(aclr), .bus(b8));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // RAM under test: ideal storage, stuck bits applied on the read path
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] fmask [DEPTH];
  logic [DW-1:0] fval  [DEPTH];
  logic [DW-1:0] rd_stage [LAT];
  logic [7:0]    mem8 [DEPTH];
  logic [7:0]    rd8_stage [LAT];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_stage[0] <= bus.mem_re ?
      ((mem[bus.mem_addr] & ~fmask[bus.mem_addr]) | (fval[bus.mem_addr] & fmask[bus.mem_addr])) : '0;
    for (int i = 1; i < LAT; i++) rd_stage[i] <= rd_stage[i-1];
    if (b8.mem_we) mem8[b8.mem_addr] <= b8.mem_wdata;
    rd8_stage[0] <= b8.mem_re ? mem8[b8.mem_addr] : 8'h00;
    for (int i = 1; i < LAT; i++) rd8_stage[i] <= rd8_stage[i-1];
  end
  assign bus.mem_rdata = rd_stage[LAT-1];
  assign b8.mem_rdata  = rd8_stage[LAT-1];

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * STEP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d required %0d", tag, obs, exp);
    end
  endtask

  int e0, wr_cnt, rd_cnt, wr_bad, both_hi, done_cnt, done_edge;
  logic [DW-1:0] w5;
  logic [7:0]    w6_8;
  logic          done8, pass8;
  logic [15:0]   err8;

  task automatic sample();
    if (bus.mem_we) begin
      if (bus.mem_addr != AW'(wr_cnt) || bus.mem_wdata != pat(int'(bus.mem_addr))) wr_bad++;
      if (bus.mem_addr == AW'(5)) w5 = bus.mem_wdata;
      wr_cnt++;
    end
    if (bus.mem_re) rd_cnt++;
    if (bus.mem_we && bus.mem_re) both_hi++;
    if (bus.done) begin
      done_cnt++;
      done_edge = edge_n;
    end
    if (b8.mem_we && b8.mem_addr == AW'(6)) w6_8 = b8.mem_wdata;
    if (b8.done) begin
      done8 = 1'b1;
      pass8 = b8.pass;
      err8  = b8.err_count;
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      fmask[a] = '0;
      fval[a]  = '0;
    end
  endtask

  task automatic run_test(input string name, input bit mid_start);
    int nerr, first, post, exp_cnt, exp_lat, exp_rd;
    nerr = 0; first = 0; post = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (((pat(a) & ~fmask[a]) | (fval[a] & fmask[a])) != pat(a)) begin
        if (nerr == 0) first = a;
        nerr++;
      end
    end
`ifdef PMTC_STOP_ON_FAIL_EN
    exp_cnt = (nerr > 0) ? 1 : 0;
    exp_lat = (nerr > 0) ? DEPTH + 1 + first + LAT : 2*DEPTH + LAT + 1;
    exp_rd  = (nerr > 0) ? first + LAT + 1 : DEPTH;
`else
    exp_cnt = nerr;
    exp_lat = 2*DEPTH + LAT + 1;
    exp_rd  = DEPTH;
`endif
    wr_cnt = 0; rd_cnt = 0; wr_bad = 0; both_hi = 0; done_cnt = 0; done_edge = 0;
    done8 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    b8.start  = 1'b1;
    e0 = edge_n + 1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.start = 1'b0;
        b8.start  = 1'b0;
      end
      if (mid_start && t == 20) bus.start = 1'b1;
      if (mid_start && t == 21) bus.start = 1'b0;
      sample();
      if (done_cnt > 0) post++;
      if (post >= 4) break;
    end
    chk({name, " done_seen"}, 32'(done_cnt > 0), 32'd1);
    chk({name, " done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, " done_latency"}, 32'(done_edge - e0), 32'(exp_lat));
    chk({name, " err_count"}, 32'(bus.err_count), 32'(exp_cnt));
    chk({name, " err_addr"}, 32'(bus.err_addr), 32'((nerr > 0) ? first : 0));
    chk({name, " pass"}, 32'(bus.pass), 32'(nerr == 0));
    chk({name, " busy"}, 32'(bus.busy), 32'd0);
    chk({name, " writes"}, 32'(wr_cnt), 32'(DEPTH));
    chk({name, " reads"}, 32'(rd_cnt), 32'(exp_rd));
    chk({name, " wdata_bad"}, 32'(wr_bad), 32'd0);
    chk({name, " we_re_overlap"}, 32'(both_hi), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.busy, bus.done, bus.pass, bus.mem_we, bus.mem_re}) |
           32'(bus.mem_addr) | 32'(bus.mem_wdata) | 32'(bus.err_count) | 32'(bus.err_addr);
  endfunction

  initial begin
    bus.start = 1'b0;
    b8.start  = 1'b0;
    clear_faults();
    repeat (2) @(negedge clk);
    chk("reset outputs", out_vec(), 32'd0);
    aclr = 1'b0;
    @(negedge clk);

    run_test("ideal", 1'b0);
    chk("ideal wdata_addr5", 32'(w5), 32'd215);
    chk("dw8 done", 32'(done8), 32'd1);
    chk("dw8 wdata_addr6", 32'(w6_8), 32'd2);
    chk("dw8 pass", 32'(pass8), 32'd1);
    chk("dw8 err_count", 32'(err8), 32'd0);

    clear_faults();
    fmask[3] = 16'h0001; fval[3] = 16'h0000;
    fmask[9] = 16'h0001; fval[9] = 16'h0000;
    run_test("stuck_3_9", 1'b0);
    run_test("start_in_read", 1'b1);

    clear_faults();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int t;
      for (t = 0; t < 50; t++) begin
        if (bus.mem_we && bus.mem_addr == AW'(7)) break;
        @(negedge clk);
      end
      chk("aclr reached_addr7", 32'(t < 50), 32'd1);
    end
    aclr = 1'b1;
    #1;
    chk("aclr outputs", out_vec(), 32'd0);
    @(negedge clk);
    chk("aclr held", out_vec(), 32'd0);
    aclr = 1'b0;
    run_test("after_aclr", 1'b0);

    for (int r = 0; r < 5; r++) begin
      int nf;
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        int a;
        a = $urandom_range(0, DEPTH-1);
        fmask[a] = DW'(1) << $urandom_range(0, DW-1);
        fval[a]  = DW'($urandom);
      end
      run_test($sformatf("random%0d", r), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
